// File: rtl/coffee_pkg.sv
// coffee_pkg: brewer state encoding, default timings and counter sizing helper
package coffee_pkg;
  typedef enum logic [2:0] {IDLE, CUP_DROP, HEAT, POUR, READY, DONE, FAULT} brew_state_t;
  localparam int CUP_CYCLES_DEF  = 4000;
  localparam int HEAT_CYCLES_DEF = 8000;
  localparam int POUR_CYCLES_DEF = 12000;
  localparam int DEBOUNCE_DEF    = 4;
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/brew_timer.sv
// brew_timer: loadable down-counter that parks at zero and flags it
module brew_timer #(
  parameter int W = 8
) (
  input  logic         clk4m,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk4m) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign done = (cnt_q == '0);
endmodule

// File: rtl/coffee_brewer.sv
// coffee_brewer: brew sequencer (cup drop, heat, pour) answering prepare_coffee
// with coffee_ready and a debounced cup_out pulse; all outputs registered.
module coffee_brewer import coffee_pkg::*; #(
  parameter int CUP_CYCLES  = CUP_CYCLES_DEF,
  parameter int HEAT_CYCLES = HEAT_CYCLES_DEF,
  parameter int POUR_CYCLES = POUR_CYCLES_DEF,
  parameter int DEBOUNCE    = DEBOUNCE_DEF
) (
  input  logic clk4m,
  input  logic rst,
  input  logic prepare_coffee,
  input  logic cup_sensor,
  output logic cup_drop,
  output logic heater_on,
  output logic pump_on,
  output logic coffee_ready,
  output logic cup_out,
  output logic busy,
  output logic fault
);
  localparam int MAXC = (CUP_CYCLES > HEAT_CYCLES) ?
                        ((CUP_CYCLES > POUR_CYCLES) ? CUP_CYCLES : POUR_CYCLES) :
                        ((HEAT_CYCLES > POUR_CYCLES) ? HEAT_CYCLES : POUR_CYCLES);
  localparam int TW = cnt_width(MAXC);
  localparam int DW = cnt_width(DEBOUNCE);

  generate
    if (CUP_CYCLES < 1 || HEAT_CYCLES < 1 || POUR_CYCLES < 1 || DEBOUNCE < 1) begin : g_bad_param
      $error("coffee_brewer: all cycle parameters must be >= 1");
    end
  endgenerate

  brew_state_t   state_q, state_d;
  logic          prev_req_q;
  logic [DW-1:0] deb_q, deb_d;
  logic [6:0]    out_q, out_d;
  logic [TW-1:0] load_val;
  logic          load, done, start;

  assign start = prepare_coffee & ~prev_req_q;

  brew_timer #(.W(TW)) u_timer (
    .clk4m    (clk4m),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    deb_d    = '0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = CUP_DROP;
        load     = 1'b1;
        load_val = TW'(CUP_CYCLES - 1);
      end
      CUP_DROP: if (done) begin
        state_d  = cup_sensor ? HEAT : FAULT;
        load     = cup_sensor;
        load_val = TW'(HEAT_CYCLES - 1);
      end
      HEAT: if (done) begin
        state_d  = POUR;
        load     = 1'b1;
        load_val = TW'(POUR_CYCLES - 1);
      end
      POUR: state_d = !cup_sensor ? FAULT : done ? READY : POUR;
      READY: begin
        deb_d   = cup_sensor ? '0 : deb_q + 1'b1;
        state_d = (!cup_sensor && deb_q == DW'(DEBOUNCE - 1)) ? DONE : READY;
      end
      DONE:    state_d = IDLE;
      default: state_d = FAULT;
    endcase
    // outputs follow the next state so the registered copy lines up with state_q
    out_d = {state_d == CUP_DROP, state_d == HEAT || state_d == POUR, state_d == POUR,
             state_d == READY, state_d == DONE, state_d != IDLE, state_d == FAULT};
  end

  always_ff @(posedge clk4m) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_req_q <= 1'b0;
      deb_q      <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      prev_req_q <= prepare_coffee;
      deb_q      <= deb_d;
      out_q      <= out_d;
    end
  end

  assign {cup_drop, heater_on, pump_on, coffee_ready, cup_out, busy, fault} = out_q;
endmodule

// File: tb/tb_coffee_brewer.sv
// tb_coffee_brewer: directed checks of the brew sequence, debounce, faults and reset
module tb_coffee_brewer;
  localparam int CUP = 4, HEAT = 8, POUR = 6, DEB = 3;
  // output vector order: cup_drop heater_on pump_on coffee_ready cup_out busy fault
  localparam logic [6:0] IDL = 7'b0000000, CD = 7'b1000010, HT = 7'b0100010,
                         PR = 7'b0110010, RDY = 7'b0001010, DN = 7'b0000110,
                         FLT = 7'b0000011;

  logic clk4m = 1'b0, rst = 1'b1, prepare_coffee = 1'b0, cup_sensor = 1'b0;
  logic cup_drop, heater_on, pump_on, coffee_ready, cup_out, busy, fault;
  logic [6:0] o;
  int n_chk = 0, n_err = 0;
  bit pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  always #5 clk4m = ~clk4m;

  coffee_brewer #(.CUP_CYCLES(CUP), .HEAT_CYCLES(HEAT), .POUR_CYCLES(POUR), .DEBOUNCE(DEB)) dut (
    .clk4m          (clk4m),
    .rst            (rst),
    .prepare_coffee (prepare_coffee),
    .cup_sensor     (cup_sensor),
    .cup_drop       (cup_drop),
    .heater_on      (heater_on),
    .pump_on        (pump_on),
    .coffee_ready   (coffee_ready),
    .cup_out        (cup_out),
    .busy           (busy),
    .fault          (fault)
  );

  assign o = {cup_drop, heater_on, pump_on, coffee_ready, cup_out, busy, fault};

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk4m);
  endtask

  task automatic expect_n(input string tag, input logic [6:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, o, exp);
      cyc();
    end
  endtask

  task automatic start_brew();
    prepare_coffee = 1'b0;
    cyc();
    prepare_coffee = 1'b1;
    cyc();
  endtask

  task automatic brew_to_ready();
    start_brew();
    expect_n("cup_drop", CD, CUP);
    expect_n("heat", HT, HEAT);
    expect_n("pour", PR, POUR);
  endtask

  initial begin
    cup_sensor = 1'b1;
    cyc();
    cyc();
    chk("reset", o, IDL);
    rst = 1'b0;
    cyc();
    chk("idle", o, IDL);

    brew_to_ready();
    expect_n("ready", RDY, 2);

    cup_sensor = 1'b0;
    expect_n("ready_debounce", RDY, DEB);
    expect_n("cup_out", DN, 1);
    expect_n("no_restart", IDL, 5);

    cup_sensor = 1'b1;
    brew_to_ready();
    expect_n("ready2", RDY, 1);
    for (int i = 0; i < 6; i++) begin
      cup_sensor = pat[i];
      chk("glitch_hold", o, RDY);
      cyc();
    end
    expect_n("glitch_cup_out", DN, 1);
    expect_n("glitch_idle", IDL, 3);

    cup_sensor = 1'b0;
    start_brew();
    expect_n("nocup_drop", CD, CUP);
    for (int i = 0; i < 20; i++) begin
      prepare_coffee = i[0];
      chk("nocup_fault", o, FLT);
      cyc();
    end
    rst = 1'b1;
    prepare_coffee = 1'b0;
    cup_sensor = 1'b1;
    cyc();
    chk("fault_cleared", o, IDL);
    rst = 1'b0;

    start_brew();
    expect_n("p_cup_drop", CD, CUP);
    expect_n("p_heat", HT, HEAT);
    expect_n("p_pour", PR, 2);
    cup_sensor = 1'b0;
    chk("p_pour3", o, PR);
    cyc();
    expect_n("pulled_fault", FLT, 5);
    rst = 1'b1;
    prepare_coffee = 1'b0;
    cup_sensor = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    chk("pulled_cleared", o, IDL);

    start_brew();
    expect_n("r_cup_drop", CD, CUP);
    expect_n("r_heat", HT, 3);
    rst = 1'b1;
    prepare_coffee = 1'b0;
    chk("r_heat_before_rst", o, HT);
    cyc();
    chk("rst_mid_heat", o, IDL);
    rst = 1'b0;
    cyc();
    expect_n("idle_after_rst", IDL, 2);
    brew_to_ready();
    expect_n("ready_after_rst", RDY, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
